ss_stream_fifo: RTL and testbench
=================================

// Module: ss_stream_fifo
// PURPOSE
//  Synchronous valid/ready stream FIFO. Sits downstream of an ss_reg_slice_n
//  chain and absorbs backpressure bursts the slices cannot hold.
//  Fully registered ready path: in_ready never depends combinationally on out_ready.
//  Single clock domain; no clock domain crossing.
// PARAMETERS
//  DATA_WIDTH   32  width of in_data/out_data
//  DEPTH        16  entries; power of 2, >= 2
//  AFULL_THRESH 12  level at which almost_full asserts (SS_FIFO_LEVEL_EN only); 1..DEPTH
// PORTS
//  clk          in   1                  clock, all logic on rising edge
//  rst_n        in   1                  async assert, active-low reset
//  in_valid     in   1                  upstream beat valid
//  in_ready     out  1                  FIFO can accept a beat (registered)
//  in_data      in   DATA_WIDTH         upstream beat payload
//  in_last      in   1                  end-of-packet marker, stored with the beat
//  out_valid    out  1                  FIFO head valid
//  out_ready    in   1                  downstream accepts head
//  out_data     out  DATA_WIDTH         head payload
//  out_last     out  1                  head end-of-packet marker
//  level        out  $clog2(DEPTH)+1    occupancy (SS_FIFO_LEVEL_EN only)
//  almost_full  out  1                  level >= AFULL_THRESH (SS_FIFO_LEVEL_EN only)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; evaluated each rising clk.
//  - Storage: DEPTH x (DATA_WIDTH+1) register array {last,data}; contents not reset.
//  - Pointers wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits; MSB is the wrap bit.
//    Empty when pointers are equal. Full when low bits are equal and the MSBs differ.
//    Pointers increment modulo 2*DEPTH.
//  - out_valid = !empty. out_data/out_last = mem[rd_ptr low bits] (first-word fall-through).
//  - Latency: a beat pushed at edge N is on out_* with out_valid=1 after edge N (cycle N+1).
//  - out_data must hold stable while out_valid=1 and out_ready=0 (AXI-stream rule).
//  - in_ready is a flop: next value = !(full after this edge's push/pop).
//    - If full and a pop occurs, in_ready rises one cycle later.
//    - A push cannot complete into a slot being freed in the same cycle.
//  - Simultaneous push+pop when non-empty: occupancy unchanged, both pointers advance.
//  - Push into empty with no pop: out_valid rises the next cycle.
//    No bypass; head is always read from storage.
//  - in_valid while in_ready=0: ignored. The beat is not stored, and upstream must hold it.
//  - Reset asserted (any time, including mid-packet):
//    - wr_ptr=rd_ptr=0, out_valid=0, in_ready=0, level=0, almost_full=0; all beats discarded.
//    - in_ready goes to 1 on the first rising clk after rst_n deasserts.
//  - out_data/out_last are don't-care while out_valid=0.
// CONFIGURATION
//  - SS_FIFO_LEVEL_EN defined:
//    - level = wr_ptr - rd_ptr (registered, 0..DEPTH) is present.
//    - almost_full = (level >= AFULL_THRESH) is present, registered, same cycle as level.
//  - SS_FIFO_LEVEL_EN undefined: level and almost_full ports and logic are
//    omitted entirely. Stream behaviour is identical in both builds.
// TESTING
//  - Reset: hold rst_n=0 3 cycles, then release
//    -> in_ready=0, out_valid=0 during reset; in_ready=1 at first edge after release.
//  - Fill: DEPTH=16, out_ready=0, push 0x00..0x0F
//    -> in_ready=0 after 16th push; 17th beat (0x10) held by upstream, not lost.
//    -> level=16, almost_full=1 from the 12th push (LEVEL_EN).
//  - Drain from full: assert out_ready -> out_data 0x00..0x0F in order, in_last preserved.
//    -> in_ready=1 one cycle after first pop; out_valid=0 after 16 pops.
//  - Streaming: in_valid=out_ready=1 for 100 cycles, incrementing data
//    -> 1-cycle latency, throughput 1 beat/cycle, level constant at 1.
//  - Random backpressure: 10k beats, 50% random in_valid and out_ready
//    -> scoreboard matches order/data/last exactly; no push while in_ready=0.
//  - Mid-packet reset: 5 beats stored, pulse rst_n low mid-cycle
//    -> out_valid drops asynchronously, level=0; old beats never reappear.

Source files
------------

// File: rtl/ss_stream_fifo.sv
// Valid/ready stream FIFO, first-word fall-through, registered in_ready.
// Define SS_FIFO_LEVEL_EN to add the level and almost_full outputs.
module ss_stream_fifo #(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    out_last
`ifdef SS_FIFO_LEVEL_EN
   ,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    almost_full
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_cfg
      $error("ss_stream_fifo: invalid DEPTH/AFULL_THRESH");
   end

   logic [DATA_WIDTH:0] mem_q [DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic                in_ready_q, in_ready_d;
   logic                push, pop;
   logic                empty, full_d;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign out_valid = !empty;
   assign in_ready  = in_ready_q;
   assign push      = in_valid & in_ready_q;
   assign pop       = out_valid & out_ready;

   // Head is always read from storage; no bypass from in_data.
   assign out_data = mem_q[rd_ptr_q[AW-1:0]][DATA_WIDTH-1:0];
   assign out_last = mem_q[rd_ptr_q[AW-1:0]][DATA_WIDTH];

   // Next pointers and next in_ready from the post-edge occupancy.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      full_d     = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                   (wr_ptr_d[AW] != rd_ptr_d[AW]);
      in_ready_d = !full_d;
   end

   // Pointer and in_ready state; everything discarded on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         in_ready_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Storage write; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
   end

`ifdef SS_FIFO_LEVEL_EN
   logic [PW-1:0] level_q, level_d;
   logic          afull_q, afull_d;

   // Occupancy and threshold flag for the post-edge state.
   always_comb begin
      level_d = wr_ptr_d - rd_ptr_d;
      afull_d = (level_d >= PW'(AFULL_THRESH));
   end

   // Registered level outputs, aligned with the pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= '0;
         afull_q <= 1'b0;
      end else begin
         level_q <= level_d;
         afull_q <= afull_d;
      end
   end

   assign level       = level_q;
   assign almost_full = afull_q;
`endif

endmodule

// File: tb/tb_ss_stream_fifo.sv
// Directed testbench for ss_stream_fifo (DEPTH=16, DATA_WIDTH=32).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ss_stream_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
`ifdef SS_FIFO_LEVEL_EN
   logic [4:0]  level;
   logic        almost_full;
`endif

   int checks = 0;
   int errors = 0;

   logic [32:0] sb [$];
   logic [32:0] exp_beat;
   int          sent;
   int          cyc;
   logic        hold;
   logic        push_now;
   logic        pop_now;

   ss_stream_fifo #(
      .DATA_WIDTH  (32),
      .DEPTH       (16),
      .AFULL_THRESH(12)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last)
`ifdef SS_FIFO_LEVEL_EN
      ,
      .level      (level),
      .almost_full(almost_full)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      // reset held for 3 cycles
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
`ifdef SS_FIFO_LEVEL_EN
      chk("rst_level", level, 0);
      chk("rst_afull", almost_full, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", in_ready, 1);
      chk("rel_out_valid", out_valid, 0);

      // fill 0x00..0x0F with no pops
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = 32'(i);
         in_last  = (i % 4 == 3);
         @(negedge clk);
         if (i == 0) begin
            chk("fill_first_valid", out_valid, 1);
            chk("fill_first_head", out_data, 0);
         end
         if (i == 14) chk("fill_ready_15", in_ready, 1);
`ifdef SS_FIFO_LEVEL_EN
         chk("fill_level", level, 64'(i + 1));
         chk("fill_afull", almost_full, 64'(i + 1 >= 12));
`endif
      end
      chk("full_in_ready", in_ready, 0);

      // 17th beat held by upstream while full
      in_data = 32'h10;
      in_last = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("full_hold_ready", in_ready, 0);
         chk("full_head_stable", out_data, 0);
      end

      // drain: 0x00..0x0F then the held 0x10
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         chk("drain_valid", out_valid, 1);
         chk("drain_data", out_data, (i < 16) ? 64'(i) : 64'h10);
         chk("drain_last", out_last, (i < 16) ? 64'(i % 4 == 3) : 64'd1);
         @(negedge clk);
         if (i == 0) chk("drain_ready_rise", in_ready, 1);
         if (i == 1) in_valid = 1'b0;
      end
      chk("drain_empty", out_valid, 0);
      chk("drain_ready", in_ready, 1);

      // streaming: push and pop every cycle
      in_valid = 1'b1;
      in_last  = 1'b0;
      for (int k = 0; k < 100; k++) begin
         in_data = 32'h100 + 32'(k);
         @(negedge clk);
         chk("stream_valid", out_valid, 1);
         chk("stream_data", out_data, 64'h100 + 64'(k));
         chk("stream_ready", in_ready, 1);
`ifdef SS_FIFO_LEVEL_EN
         chk("stream_level", level, 1);
`endif
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("stream_end_empty", out_valid, 0);

      // random backpressure with scoreboard
      sent = 0;
      cyc  = 0;
      hold = 1'b0;
      out_ready = 1'b0;
      while ((sent < 10000 || sb.size() != 0) && cyc < 60000) begin
         if (!hold) begin
            if (sent < 10000 && $urandom_range(0, 1) == 1) begin
               in_valid = 1'b1;
               in_data  = $urandom;
               in_last  = ($urandom_range(0, 1) == 1);
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = (sent >= 10000) ? 1'b1 : ($urandom_range(0, 1) == 1);
         #1;
         chk("rand_valid", out_valid, 64'(sb.size() != 0));
         push_now = in_valid && in_ready;
         pop_now  = out_valid && out_ready;
         if (pop_now && sb.size() != 0) begin
            exp_beat = sb.pop_front();
            chk("rand_data", out_data, 64'(exp_beat[31:0]));
            chk("rand_last", out_last, 64'(exp_beat[32]));
         end
         if (push_now) begin
            sb.push_back({in_last, in_data});
            sent++;
         end
         hold = in_valid && !push_now;
         @(negedge clk);
         cyc++;
      end
      chk("rand_complete", 64'(sent), 10000);
      chk("rand_sb_empty", 64'(sb.size()), 0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);

      // mid-packet reset with 5 beats stored
      in_valid = 1'b1;
      in_last  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_data = 32'hA0 + 32'(i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("pre_rst_valid", out_valid, 1);
`ifdef SS_FIFO_LEVEL_EN
      chk("pre_rst_level", level, 5);
`endif
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_ready", in_ready, 0);
`ifdef SS_FIFO_LEVEL_EN
      chk("async_rst_level", level, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst2_ready", in_ready, 1);
      chk("rst2_valid", out_valid, 0);
      in_valid = 1'b1;
      in_data  = 32'hBB;
      in_last  = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("rst2_new_head", out_data, 32'hBB);
      chk("rst2_new_last", out_last, 1);
      @(negedge clk);
      chk("rst2_no_old", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
